// File: rtl/exc_ctrl.sv
// Exception controller: arbitrates an undecodable-opcode trap and masked external
// interrupts into a single exception request. It holds the captured cause through
// the handler until ERET, and keeps a saturating count of acknowledged exceptions.
module exc_ctrl #(
  parameter int unsigned N_IRQ = 4,  // 1..8 channels
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ExtIRQ,
  input  logic [N_IRQ-1:0] IrqMask,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic             ExcAck,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic [N_IRQ-1:0] ExtIAck,
  output logic             InHandler,
  output logic             DoubleFault,
  output logic [CNT_W-1:0] ExcCount
);

  typedef enum logic [1:0] {StIdle, StReq, StHandler} state_e;

  localparam logic [3:0] CauseNotAnInstr = 4'b0010;

  state_e           r_state, w_state_d;
  logic [3:0]       r_cause, w_cause_d;
  logic [2:0]       r_idx, w_idx_d;
  logic             r_df;
  logic [CNT_W-1:0] r_cnt;

  logic [N_IRQ-1:0] w_pend;
  logic             w_any;
  logic [2:0]       w_low;
  logic             w_take;

  assign w_pend = ExtIRQ & IrqMask;

  // Lowest enabled pending channel wins; scan from the top so the lowest index lands last.
  always_comb begin
    w_any = 1'b0;
    w_low = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_any = 1'b1;
        w_low = 3'(i);
      end
    end
  end

  // Next-state logic: capture cause on entry, freeze it through REQ/HANDLER, clear on ERET.
  always_comb begin
    w_state_d = r_state;
    w_cause_d = r_cause;
    w_idx_d   = r_idx;
    w_take    = 1'b0;
    case (r_state)
      StIdle: begin
        if (NotAnInstr) begin
          w_state_d = StReq;
          w_cause_d = CauseNotAnInstr;
          w_idx_d   = '0;
        end else if (w_any) begin
          w_state_d = StReq;
          w_cause_d = {1'b1, w_low};
          w_idx_d   = w_low;
        end
      end
      StReq: begin
        // ERet is deliberately ignored here; only the pipeline's acknowledge moves us on.
        if (ExcAck) begin
          w_state_d = StHandler;
          w_take    = 1'b1;
        end
      end
      StHandler: begin
        if (ERet) begin
          w_state_d = StIdle;
          w_cause_d = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cause_d = '0;
      end
    endcase
  end

  // Output decode; the acknowledge is combinational so it lines up with ExcAck.
  always_comb begin
    Exc       = (r_state == StReq);
    InHandler = (r_state == StHandler);
    EStatus   = r_cause;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      ExtIAck[i] = w_take && r_cause[3] && (r_idx == 3'(i));
    end
  end

  // State and captured-cause registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cause <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cause <= w_cause_d;
      r_idx   <= w_idx_d;
    end
  end

  // Sticky double-fault: a bad opcode while a handler is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_df <= 1'b0;
    end else if (r_state == StHandler && NotAnInstr) begin
      r_df <= 1'b1;
    end
  end

  // Saturating count of acknowledged exceptions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_take && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign DoubleFault = r_df;
  assign ExcCount    = r_cnt;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: a directed vector table, hand-written corner
// sequences (masking, saturation, asynchronous reset) and random stimulus scored
// against a behavioural model.
module tb_exc_ctrl;

  localparam int N  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ExtIRQ, IrqMask;
  logic          NotAnInstr, ERet, ExcAck;
  logic          Exc, InHandler, DoubleFault;
  logic [3:0]    EStatus;
  logic [N-1:0]  ExtIAck;
  logic [CW-1:0] ExcCount;

  always #5 clk = ~clk;

  exc_ctrl #(.N_IRQ(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .IrqMask    (IrqMask),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .ExcAck     (ExcAck),
    .Exc        (Exc),
    .EStatus    (EStatus),
    .ExtIAck    (ExtIAck),
    .InHandler  (InHandler),
    .DoubleFault(DoubleFault),
    .ExcCount   (ExcCount)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: "request pending", "handler busy", captured cause/channel.
  bit         m_pend, m_busy, m_df;
  logic [3:0] m_cause;
  int         m_idx;
  int         m_cnt;

  typedef struct {
    logic [3:0] irq, mask;
    logic       nai, eret, ack;
    logic       exc;
    logic [3:0] st, iack;
    logic       inh, df;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [18:0] outs();
    return {Exc, EStatus, ExtIAck, InHandler, DoubleFault, ExcCount};
  endfunction

  task automatic check(input string nm, input logic [18:0] exp);
    n_vec++;
    if (outs() !== exp) begin
      n_err++;
      $display("FAIL %s: got {exc,st,iack,inh,df,cnt}=%h required %h at %0t", nm, outs(), exp,
               $time);
    end
  endtask

  task automatic drive(input logic [3:0] irq, mask, input logic nai, eret, ack);
    ExtIRQ = irq; IrqMask = mask; NotAnInstr = nai; ERet = eret; ExcAck = ack;
    #1;
  endtask

  task automatic model_reset();
    m_pend = 0; m_busy = 0; m_df = 0; m_cause = '0; m_idx = 0; m_cnt = 0;
  endtask

  // Called right at a negedge: drive, check against model, advance model, wait a cycle.
  task automatic model_step(input string nm, input logic [3:0] irq, mask,
                            input logic nai, eret, ack);
    logic [3:0] iack, p, lo;
    drive(irq, mask, nai, eret, ack);
    iack = (m_pend && ack && m_cause[3]) ? 4'(1 << m_idx) : 4'b0000;
    check(nm, {m_pend, m_cause, iack, m_busy, m_df, 8'(m_cnt)});
    if (m_pend) begin
      if (ack) begin
        m_pend = 0; m_busy = 1;
        m_cnt  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end
    end else if (m_busy) begin
      if (nai) m_df = 1;
      if (eret) begin m_busy = 0; m_cause = '0; end
    end else begin
      p = irq & mask;
      if (nai) begin
        m_pend = 1; m_cause = 4'b0010;
      end else if (p != 0) begin
        lo      = p & (~p + 4'd1);  // isolate lowest set bit
        m_idx   = $clog2(lo);
        m_cause = 4'b1000 | 4'(m_idx);
        m_pend  = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    //          irq      mask     nai   eret  ack   exc   st       iack     inh   df    cnt
    tbl[0]  = '{4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1001, 4'b0010, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1, 1'b0, 8'd1};
    tbl[3]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1, 1'b0, 8'd1};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1, 1'b1, 8'd1};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b1, 1'b1, 8'd1};
    tbl[6]  = '{4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd1};
    tbl[7]  = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'd2};
    tbl[9]  = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 8'd2};
    tbl[10] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd2};
    tbl[11] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd2};
    tbl[12] = '{4'b1111, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd2};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1010, 4'b0000, 1'b0, 1'b1, 8'd2};
    tbl[14] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b0100, 1'b0, 1'b1, 8'd2};
    tbl[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 8'd3};

    @(negedge clk);
    do_reset();

    // Directed table; vector 0 is applied straight after reset release.
    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].irq, tbl[k].mask, tbl[k].nai, tbl[k].eret, tbl[k].ack);
      check($sformatf("tbl%0d", k),
            {tbl[k].exc, tbl[k].st, tbl[k].iack, tbl[k].inh, tbl[k].df, tbl[k].cnt});
      @(negedge clk);
    end

    // Fully masked requests for 10 cycles never leave idle.
    do_reset();
    for (int k = 0; k < 10; k++) model_step("masked", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Counter saturation: 257 acknowledged exceptions.
    do_reset();
    for (int k = 0; k < 257; k++) begin
      model_step("sat_req", 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
      model_step("sat_ack", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
      model_step("sat_ret", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    end
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("sat_final", {1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'hFF});
    @(negedge clk);

    // Asynchronous reset while in REQ: outputs clear before any clock edge.
    do_reset();
    model_step("pre_async", 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("in_req", {1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 8'd0});
    #1 reset = 1'b0;
    #1 check("async_reset", 19'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    model_step("post_reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Random stimulus against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      model_step("rand", 4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter N_IRQ, default 4, SHALL set the number of external interrupt channels; legal range 1..8.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the exception counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ExtIRQ  input  N_IRQ  SHALL be level-sensitive external interrupt requests, bit i = channel i.
REQ-006 IrqMask  input  N_IRQ  SHALL enable channel i when bit i = 1.
REQ-007 NotAnInstr  input  1  SHALL flag an undecodable opcode from the decoder.
REQ-008 ERet  input  1  SHALL flag an ERET instruction retiring.
REQ-009 ExcAck  input  1  SHALL flag that the pipeline has taken the exception redirect.
REQ-010 Exc  output  1  SHALL request an exception redirect from the pipeline.
REQ-011 EStatus  output  4  SHALL give the cause code of the current exception.
REQ-012 ExtIAck  output  N_IRQ  SHALL give a one-hot acknowledge to the serviced channel.
REQ-013 InHandler  output  1  SHALL flag that an exception handler is executing.
REQ-014 DoubleFault  output  1  SHALL be a sticky flag for an invalid opcode seen inside a handler.
REQ-015 ExcCount  output  CNT_W  SHALL count acknowledged exceptions.

Function
REQ-016 The FSM SHALL have three states: IDLE, REQ and HANDLER.
REQ-017 IDLE SHALL drive Exc=0 and InHandler=0; EStatus SHALL hold 4'b0000.
REQ-018 In IDLE with NotAnInstr=1, the next state SHALL be REQ with cause 4'b0010.
REQ-019 In IDLE with NotAnInstr=0 and any (ExtIRQ & IrqMask) bit set, the next state SHALL be REQ, capturing the lowest set index i, with cause 4'b1000 | i.
REQ-020 Priority SHALL be NotAnInstr above any IRQ, and a lower IRQ index above a higher one.
REQ-021 Masked channels SHALL never cause a transition or an acknowledge.
REQ-022 REQ SHALL drive Exc=1 and the registered cause on EStatus; entry latency SHALL be 1 cycle from the request.
REQ-023 The cause and index captured in REQ SHALL stay frozen even if ExtIRQ or IrqMask changes; a committed request is not withdrawn.
REQ-024 In REQ with ExcAck=1, the next state SHALL be HANDLER and ExcCount SHALL increment by 1, saturating at all-ones.
REQ-025 In REQ with ExcAck=1, ExtIAck SHALL assert bit i combinationally in that same cycle when the cause is an IRQ; ExtIAck SHALL otherwise be all-zero.
REQ-026 In REQ, ERet SHALL be ignored; when ExcAck and ERet arrive together, ExcAck SHALL win.
REQ-027 HANDLER SHALL drive Exc=0 and InHandler=1, and SHALL hold EStatus at the captured cause.
REQ-028 HANDLER SHALL not nest: new IRQs and NotAnInstr SHALL not change the state or the cause.
REQ-029 NotAnInstr=1 in HANDLER SHALL set DoubleFault=1, which is cleared only by reset.
REQ-030 In HANDLER with ERet=1, the next state SHALL be IDLE and EStatus SHALL clear to 0; requests present in that cycle SHALL be sampled in IDLE on the following cycle.
REQ-031 ERet in IDLE and ExcAck outside REQ SHALL be ignored.

Reset
REQ-032 While reset=0, the FSM SHALL enter IDLE and outputs SHALL be Exc=0, EStatus=0, ExtIAck=0, InHandler=0, DoubleFault=0, ExcCount=0; this applies mid-operation in every state.
REQ-033 After reset releases, the first request SHALL be sampled on the first rising clk edge.

Verification
REQ-034 N_IRQ=4, IrqMask=4'b1111, ExtIRQ=4'b0110 in IDLE -> next cycle Exc=1, EStatus=4'b1001; ExcAck pulse -> ExtIAck=4'b0010 that cycle, then InHandler=1, ExcCount=1.
REQ-035 NotAnInstr=1 with ExtIRQ=4'b0001 in IDLE -> EStatus=4'b0010; ExtIAck stays 0 on ExcAck.
REQ-036 IrqMask=4'b0000, ExtIRQ=4'b1111 for 10 cycles -> Exc stays 0, state stays IDLE.
REQ-037 In HANDLER: NotAnInstr=1 -> DoubleFault=1, EStatus unchanged; ERet=1 -> IDLE, EStatus=0, DoubleFault stays 1.
REQ-038 Force ExcCount to all-ones via 2^CNT_W acknowledged exceptions -> one further acknowledged exception leaves it at all-ones.
REQ-039 reset=0 asserted asynchronously in REQ -> Exc=0 immediately, without waiting for clk; after release, the FSM is in IDLE with all outputs 0.
